// File: rtl/vga_mode_sequencer.sv
// vga_mode_sequencer
// Sits between hvsync_gen and the VGA pins in the pixel-clock domain.
// It synchronises the mode switches and v_sync, debounces the switches in
// whole frames, applies a new mode only at a frame boundary, steps a cycling
// colour every COLOR_FRAMES frames, and registers the gated R/G/B pattern.
`timescale 1ns/1ps

module vga_mode_sequencer #(
    parameter int COLOR_FRAMES = 60,
    parameter int DEB_FRAMES   = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] sw,
    input  logic       v_sync,
    input  logic       onscreen,
    output logic       R,
    output logic       G,
    output logic       B,
    output logic [2:0] mode,
    output logic [2:0] color,
    output logic       frame_tick
);

    localparam int FW = (COLOR_FRAMES > 1) ? $clog2(COLOR_FRAMES) : 1;
    localparam int DW = (DEB_FRAMES > 1) ? $clog2(DEB_FRAMES) : 1;
    localparam logic [FW-1:0] FCNT_LAST = FW'(COLOR_FRAMES - 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_FRAMES - 1);

    logic [2:0]    r_swMeta;
    logic [2:0]    r_swSync;
    logic          r_vsMeta;
    logic          r_vsSync;
    logic          r_vsPrev;
    logic          r_frameTick;
    logic [2:0]    r_swCand;
    logic [DW-1:0] r_debCnt;
    logic [2:0]    r_swStable;
    logic [2:0]    r_mode;
    logic [FW-1:0] r_fcnt;
    logic [2:0]    r_color;
    logic [2:0]    r_rgb;
    logic [2:0]    w_pattern;

    // Two-flop synchronisers; v_sync chain presets high so reset never looks like a falling edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_swMeta <= 3'd0;
            r_swSync <= 3'd0;
            r_vsMeta <= 1'b1;
            r_vsSync <= 1'b1;
            r_vsPrev <= 1'b1;
        end else begin
            r_swMeta <= sw;
            r_swSync <= r_swMeta;
            r_vsMeta <= v_sync;
            r_vsSync <= r_vsMeta;
            r_vsPrev <= r_vsSync;
        end
    end

    // Registered one-cycle frame pulse on the synchronised v_sync falling edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frameTick <= 1'b0;
        end else begin
            r_frameTick <= r_vsPrev & ~r_vsSync;
        end
    end

    // Frame-rate debounce: a switch value must be seen on DEB_FRAMES+1 consecutive ticks
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_swCand   <= 3'd0;
            r_debCnt   <= '0;
            r_swStable <= 3'd0;
        end else if (r_frameTick) begin
            if (r_swSync != r_swCand) begin
                r_swCand <= r_swSync;
                r_debCnt <= '0;
            end else if (r_debCnt != DEB_LAST) begin
                r_debCnt <= r_debCnt + 1'b1;
            end else begin
                r_swStable <= r_swCand;
            end
        end
    end

    // Mode only changes on a tick, taking the stable value from before this tick's debounce update
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode <= 3'd0;
        end else if (r_frameTick) begin
            r_mode <= r_swStable;
        end
    end

    // Colour step timer counted in whole frames; the colour wraps naturally at 3 bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fcnt  <= '0;
            r_color <= 3'd0;
        end else if (r_frameTick) begin
            if (r_fcnt == FCNT_LAST) begin
                r_fcnt  <= '0;
                r_color <= r_color + 3'd1;
            end else begin
                r_fcnt <= r_fcnt + 1'b1;
            end
        end
    end

    // Pattern selection as {R,G,B}; unused modes fall back to white
    always_comb begin
        w_pattern = 3'b111;
        case (r_mode)
            3'd0:    w_pattern = 3'b111;
            3'd1:    w_pattern = {r_color[0], r_color[1], r_color[2]};
            3'd2:    w_pattern = r_color[0] ? 3'b000 : 3'b111;
            3'd3:    w_pattern = 3'b000;
            default: w_pattern = 3'b111;
        endcase
    end

    // Blank outside the visible area and register the pins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rgb <= 3'b000;
        end else begin
            r_rgb <= w_pattern & {3{onscreen}};
        end
    end

    assign R          = r_rgb[2];
    assign G          = r_rgb[1];
    assign B          = r_rgb[0];
    assign mode       = r_mode;
    assign color      = r_color;
    assign frame_tick = r_frameTick;

endmodule
